// File: rtl/prio_change_logger_pkg.sv
// Shared constants for the priority encoder and the change logger.
// Entry format is {idle, 3'b000, idx[3:0]}.
package prio_change_logger_pkg;

    localparam int         DEPTH_DEFAULT     = 8;
    localparam int         ENTRY_W           = 8;
    localparam int         COUNT_W           = 5;
    localparam logic [7:0] IDLE_CODE_DEFAULT = 8'hF0;
    localparam logic [7:0] IDLE_ENTRY        = 8'h80;

    // The encoder only ever emits a winning index (0..15) or its idle code.
    function automatic logic is_legal_code(input logic [7:0] code, input logic [7:0] idle_code);
        return (code <= 8'h0F) || (code == idle_code);
    endfunction

    function automatic logic [ENTRY_W-1:0] encode_entry(input logic [7:0] code, input logic [7:0] idle_code);
        return (code == idle_code) ? IDLE_ENTRY : {4'b0000, code[3:0]};
    endfunction

endpackage

// File: rtl/prio_change_logger_sync_fifo.sv
// First-word fall-through FIFO with wrapping pointers and a separate occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_eff;
    logic w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_pop_eff = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_eff);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Contents are not cleared on reset; resetting the pointers and count discards them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_eff) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push_ok, w_pop_eff})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prio_change_logger.sv
// Logs changes of a priority encoder's output into a FIFO, with a two-sample
// glitch filter and sticky overflow / illegal-code flags.
module prio_change_logger
    import prio_change_logger_pkg::*;
#(
    parameter int         DEPTH     = DEPTH_DEFAULT,
    parameter logic [7:0] IDLE_CODE = IDLE_CODE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         code_in,
    input  logic               pop,
    input  logic               clr_flags,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               overflow,
    output logic               illegal
);

    logic [7:0] r_s0;
    logic [7:0] r_s1;
    logic [7:0] r_last_code;
    logic       r_overflow;
    logic       r_illegal;

    logic               w_stable;
    logic               w_legal;
    logic               w_push;
    logic               w_illegal_seen;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_entry;

    assign w_stable       = ena && (r_s0 == r_s1);
    assign w_legal        = is_legal_code(r_s1, IDLE_CODE);
    assign w_push         = w_stable && w_legal && (r_s1 != r_last_code);
    assign w_illegal_seen = w_stable && !w_legal;
    assign w_drop         = w_push && w_full && !pop;
    assign w_entry        = encode_entry(r_s1, IDLE_CODE);

    // last_code follows every accepted change, even one the full FIFO drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0        <= IDLE_CODE;
            r_s1        <= IDLE_CODE;
            r_last_code <= IDLE_CODE;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (ena) begin
                r_s0 <= code_in;
                r_s1 <= r_s0;
            end
            if (w_push) begin
                r_last_code <= r_s1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_illegal_seen) begin
                r_illegal <= 1'b1;
            end else if (clr_flags) begin
                r_illegal <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (COUNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_pop     (pop),
        .i_wr_data (w_entry),
        .o_rd_data (rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    assign full     = w_full;
    assign rd_valid = !w_empty;
    assign overflow = r_overflow;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_prio_change_logger.sv
// Directed and randomized bench for prio_change_logger, checked against a
// queue-based reference model of the logging rules.
module tb_prio_change_logger;

    localparam int         DEPTH = 8;
    localparam logic [7:0] IDLE  = 8'hF0;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ena       = 1'b0;
    logic       pop       = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] code_in   = IDLE;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       illegal;

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [7:0] mNewest;
    logic [7:0] mPrev;
    logic [7:0] mLast;
    logic [7:0] mFifo[$];
    logic       mOvf;
    logic       mIll;

    prio_change_logger #(.DEPTH(DEPTH), .IDLE_CODE(IDLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .code_in   (code_in),
        .pop       (pop),
        .clr_flags (clr_flags),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("count",    {3'b000, count},    8'(mFifo.size()));
        checkOne("rd_valid", {7'd0, rd_valid},   {7'd0, (mFifo.size() != 0)});
        checkOne("rd_data",  rd_data,            (mFifo.size() != 0) ? mFifo[0] : 8'h00);
        checkOne("full",     {7'd0, full},       {7'd0, (mFifo.size() == DEPTH)});
        checkOne("overflow", {7'd0, overflow},   {7'd0, mOvf});
        checkOne("illegal",  {7'd0, illegal},    {7'd0, mIll});
    endtask

    task automatic modelReset();
        mNewest = IDLE;
        mPrev   = IDLE;
        mLast   = IDLE;
        mFifo.delete();
        mOvf    = 1'b0;
        mIll    = 1'b0;
    endtask

    // One clock edge of behaviour: a code counts once its last two enabled samples agree.
    task automatic modelStep(input logic [7:0] code, input logic en, input logic pp, input logic clr);
        bit         popEff;
        bit         wasFull;
        bit         doPush;
        bit         drop;
        bit         illSet;
        logic [7:0] c;
        popEff  = pp && (mFifo.size() > 0);
        wasFull = (mFifo.size() == DEPTH);
        doPush  = 0;
        drop    = 0;
        illSet  = 0;
        c       = mPrev;
        if (en && (mNewest == mPrev)) begin
            if (!((c <= 8'h0F) || (c == IDLE))) begin
                illSet = 1;
            end else if (c != mLast) begin
                doPush = 1;
                mLast  = c;
            end
        end
        if (popEff) begin
            void'(mFifo.pop_front());
        end
        if (doPush) begin
            if (!wasFull || popEff) begin
                mFifo.push_back((c == IDLE) ? 8'h80 : {4'h0, c[3:0]});
            end else begin
                drop = 1;
            end
        end
        mOvf = drop   ? 1'b1 : (clr ? 1'b0 : mOvf);
        mIll = illSet ? 1'b1 : (clr ? 1'b0 : mIll);
        if (en) begin
            mPrev   = mNewest;
            mNewest = code;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic en, input logic pp, input logic clr);
        code_in   = code;
        ena       = en;
        pop       = pp;
        clr_flags = clr;
        @(posedge clk);
        modelStep(code, en, pp, clr);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        code_in   = IDLE;
        ena       = 1'b0;
        pop       = 1'b0;
        clr_flags = 1'b0;
        #2;
        modelReset();
        checkOne("reset_count",   {3'b000, count}, 8'h00);
        checkOne("reset_valid",   {7'd0, rd_valid}, 8'h00);
        checkOne("reset_rd_data", rd_data, 8'h00);
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic holdCode(input logic [7:0] code, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(code, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] rc;
        int         holdLeft;
        int         r;

        $display("[TB] start");
        doReset();

        // Latency: a held code appears after the third capturing edge.
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        checkOne("lat_not_yet", {3'b000, count}, 8'h00);
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b0);
        checkOne("lat_count", {3'b000, count}, 8'h01);
        checkOne("lat_data",  rd_data, 8'h05);

        // Single-cycle glitch is filtered.
        doReset();
        applyStimulus(8'h0A, 1'b1, 1'b0, 1'b0);
        holdCode(IDLE, 4);
        checkOne("glitch_count", {3'b000, count}, 8'h00);

        // Repeated code, idle and index 15.
        doReset();
        holdCode(8'h03, 8);
        holdCode(IDLE, 4);
        holdCode(8'h0F, 4);
        checkOne("seq_count", {3'b000, count}, 8'h03);
        checkOne("seq_head0", rd_data, 8'h03);
        applyStimulus(8'h0F, 1'b1, 1'b1, 1'b0);
        checkOne("seq_head1", rd_data, 8'h80);
        applyStimulus(8'h0F, 1'b1, 1'b1, 1'b0);
        checkOne("seq_head2", rd_data, 8'h0F);

        // Nine distinct codes overflow the FIFO; then clear the flag.
        doReset();
        for (int k = 0; k < 9; k++) begin
            holdCode(8'(k), 3);
        end
        checkOne("ovf_full",  {7'd0, full}, 8'h01);
        checkOne("ovf_count", {3'b000, count}, 8'h08);
        checkOne("ovf_flag",  {7'd0, overflow}, 8'h01);
        checkOne("ovf_head",  rd_data, 8'h00);
        applyStimulus(8'h08, 1'b1, 1'b0, 1'b1);
        checkOne("ovf_clr", {7'd0, overflow}, 8'h00);

        // Push and pop together while full.
        applyStimulus(8'h0A, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h0A, 1'b1, 1'b1, 1'b0);
        checkOne("fullpp_count", {3'b000, count}, 8'h08);
        checkOne("fullpp_ovf",   {7'd0, overflow}, 8'h00);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(8'h0A, 1'b1, 1'b1, 1'b0);
        end
        checkOne("fullpp_tail", rd_data, 8'h0A);

        // Illegal code, then pop on empty.
        doReset();
        holdCode(8'h42, 3);
        checkOne("ill_flag",  {7'd0, illegal}, 8'h01);
        checkOne("ill_count", {3'b000, count}, 8'h00);
        applyStimulus(8'h42, 1'b1, 1'b1, 1'b0);
        checkOne("ill_popempty", rd_data, 8'h00);
        // Set beats clear while the illegal code stays stable.
        applyStimulus(8'h42, 1'b1, 1'b0, 1'b1);
        checkOne("ill_setwins", {7'd0, illegal}, 8'h01);

        // Randomized traffic.
        doReset();
        rc       = IDLE;
        holdLeft = 0;
        for (int n = 0; n < 600; n++) begin
            if (holdLeft == 0) begin
                r = int'($urandom_range(0, 19));
                if (r < 16)       rc = 8'(r);
                else if (r < 18)  rc = IDLE;
                else if (r == 18) rc = 8'($urandom_range(8'h10, 8'hEF));
                holdLeft = int'($urandom_range(1, 4));
            end
            holdLeft--;
            applyStimulus(rc, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
                          ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset in the middle of traffic discards everything.
        holdCode(8'h07, 3);
        holdCode(8'h09, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOne("async_count", {3'b000, count}, 8'h00);
        checkOne("async_valid", {7'd0, rd_valid}, 8'h00);
        checkOne("async_data",  rd_data, 8'h00);
        doReset();
        holdCode(IDLE, 4);
        checkOne("post_reset_idle", {3'b000, count}, 8'h00);
        holdCode(8'h01, 3);
        checkOne("post_reset_push", rd_data, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/prio_change_logger.md
PRIO_CHANGE_LOGGER -- requirements
Module: prio_change_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter IDLE_CODE, default 8'hF0, the encoder's no-request code.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  high enables sampling and pushing; pops are served regardless.
REQ-006 SHALL have port code_in  input  8  priority-encoder output: 8'h00-8'h0F = winning index, IDLE_CODE = none.
REQ-007 SHALL have port pop  input  1  consumer read strobe, one entry per high cycle.
REQ-008 SHALL have port rd_data  output  8  head entry {idle, 3'b000, idx[3:0]}; idle=1 implies idx=0.
REQ-009 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port count  output  5  current occupancy, 0..DEPTH.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: an entry was dropped.
REQ-013 SHALL have port illegal  output  1  sticky: a stable code outside 8'h00-8'h0F and IDLE_CODE was seen.
REQ-014 SHALL have port clr_flags  input  1  clears overflow and illegal.

Function
REQ-015 SHALL register code_in into s0, then s0 into s1, every cycle ena is high; both hold when ena is low.
REQ-016 SHALL treat a sample as stable when s0 == s1 and ena is high; unstable samples are ignored (glitch filter).
REQ-017 SHALL hold last_code, the last accepted code; its reset value is IDLE_CODE.
REQ-018 SHALL generate a push when a stable s1 is legal and differs from last_code, and SHALL update last_code to s1 in the same cycle.
REQ-019 SHALL encode a pushed entry as {1'b1, 7'b0} for IDLE_CODE, else {4'b0000, s1[3:0]}.
REQ-020 SHALL NOT push and SHALL NOT update last_code on a stable illegal code; it SHALL set illegal instead.
REQ-021 SHALL make a code_in value held constant from edge N visible as rd_valid/rd_data after edge N+3 when the FIFO was empty.
REQ-022 SHALL present the FIFO head combinationally from storage (first-word fall-through); rd_data is 8'h00 when empty.
REQ-023 SHALL advance the head on pop when rd_valid is high; pop when empty SHALL be ignored.
REQ-024 SHALL drop a push when full and pop is low, set overflow, and still update last_code.
REQ-025 SHALL, on simultaneous push and pop while full, perform both with count unchanged and no overflow.
REQ-026 SHALL, on simultaneous push and pop while empty, perform the push only (count becomes 1).
REQ-027 SHALL use wrapping read/write pointers modulo DEPTH, with count tracked separately.
REQ-028 SHALL give a set event priority over clr_flags in the same cycle for both sticky flags.

Reset
REQ-029 SHALL, on rst_n low, immediately set s0, s1 and last_code to IDLE_CODE, pointers and count to 0, overflow and illegal to 0, rd_valid to 0, full to 0, and rd_data to 8'h00.
REQ-030 SHALL discard FIFO contents on reset asserted mid-operation; the first post-reset push occurs only for a code differing from IDLE_CODE.

Structure
REQ-031 SHALL place IDLE_CODE, the default DEPTH, the entry width (8) and the idle-entry constant 8'h80 in a shared package used by the encoder and this block.
REQ-032 SHALL implement storage as one sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count); sampling, change detection and flags stay in the top.

Verification
REQ-033 Reset, then code_in=8'h05 held from edge 0 -> after edge 3 rd_valid=1, rd_data=8'h05, count=1.
REQ-034 code_in glitches to 8'h0A for exactly one cycle, otherwise IDLE_CODE -> no push, count stays 0.
REQ-035 Sequence 8'h03, 8'h03, IDLE_CODE, 8'h0F (each held 4 cycles), no pop -> three entries 8'h03, 8'h80, 8'h0F in order.
REQ-036 Nine distinct stable codes with DEPTH=8, no pop -> full=1, count=8, overflow=1, head still first entry; then clr_flags -> overflow=0.
REQ-037 Full FIFO, new code pushed in the same cycle as pop -> count stays 8, overflow stays 0, new entry at tail.
REQ-038 Stable code_in=8'h42 -> illegal=1, no push; then pop on empty FIFO -> count stays 0, rd_data=8'h00.
